// File: rtl/sevenseg_pkg.sv
// Shared constants for the memory-mapped seven-segment display block:
// register offsets, CTRL field positions and the active-low hex glyph table.
// Pure definitions, no logic.
package sevenseg_pkg;

  // Register offsets, decoded from iomem_addr[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // CTRL field positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_DP_LSB    = 4;
  localparam int CTRL_BLANK_LSB = 8;

  // Active-low glyphs, segment a at bit 0 through g at bit 6.
  // Entry k is the glyph for hex value k (listed here from F down to 0).
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/sevenseg_decode.sv
// Hex nibble to active-low seven-segment glyph lookup.
// Purely combinational, zero latency.
// No handshake; output follows input.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/iomem_sevenseg.sv
// Memory-mapped 4-digit multiplexed seven-segment display driver.
// Bus: ready pulses one cycle after selection; display outputs lag the digit index by one cycle.
// A held request is served once per ready pulse; no other backpressure.
module iomem_sevenseg
  import sevenseg_pkg::*;
#(
  parameter logic [7:0] ADDR_HI  = 8'h04,
  parameter int         TICK_DIV = 12500
) (
  input  logic        CLKOUT,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0] data_q;
  logic        en_q;
  logic [3:0]  dp_q;
  logic [3:0]  blank_q;
  logic [15:0] tick_q;
  logic [1:0]  digit_q;

  logic        sel;
  logic        wr;
  logic [1:0]  off;
  logic [31:0] rd_val;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic        unused_bits;

  // Address bits outside the block select and register offset are don't-care.
  assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16]};

  // Not re-selecting while ready is high gives one service per ready pulse.
  assign sel = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
  assign wr  = sel && (iomem_wstrb != 4'b0000);
  assign off = iomem_addr[3:2];

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_DATA:   rd_val[15:0] = data_q;
      OFF_CTRL: begin
        rd_val[CTRL_EN_BIT]           = en_q;
        rd_val[CTRL_DP_LSB +: 4]      = dp_q;
        rd_val[CTRL_BLANK_LSB +: 4]   = blank_q;
      end
      OFF_STATUS: rd_val[2:0] = {en_q, digit_q};
      OFF_RSVD:   rd_val = '0;
      default:    rd_val = '0;
    endcase
  end

  // Bus handshake: one-cycle ready pulse with read data captured alongside it.
  always_ff @(posedge CLKOUT) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= sel;
      if (sel) iomem_rdata <= rd_val;
    end
  end

  // Register writes, applied per byte lane; STATUS and reserved ignore writes.
  always_ff @(posedge CLKOUT) begin
    if (!resetn) begin
      data_q  <= '0;
      en_q    <= 1'b0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (wr) begin
      case (off)
        OFF_DATA: begin
          if (iomem_wstrb[0]) data_q[7:0]  <= iomem_wdata[7:0];
          if (iomem_wstrb[1]) data_q[15:8] <= iomem_wdata[15:8];
        end
        OFF_CTRL: begin
          if (iomem_wstrb[0]) begin
            en_q <= iomem_wdata[CTRL_EN_BIT];
            dp_q <= iomem_wdata[CTRL_DP_LSB +: 4];
          end
          if (iomem_wstrb[1]) blank_q <= iomem_wdata[CTRL_BLANK_LSB +: 4];
        end
        default: ;
      endcase
    end
  end

  // Scan timing: held at zero while disabled, so enabling always starts at digit 0.
  always_ff @(posedge CLKOUT) begin
    if (!resetn || !en_q) begin
      tick_q  <= '0;
      digit_q <= '0;
    end else if (tick_q == TICK_LAST) begin
      tick_q  <= '0;
      digit_q <= digit_q + 2'd1;
    end else begin
      tick_q <= tick_q + 16'd1;
    end
  end

  assign nibble = data_q[{digit_q, 2'b00} +: 4];

  sevenseg_decode u_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Registered display drive for the current digit slot.
  always_ff @(posedge CLKOUT) begin
    if (!resetn || !en_q) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= blank_q[digit_q] ? 4'hF : ~(4'b0001 << digit_q);
      seg <= glyph;
      dp  <= ~dp_q[digit_q];
    end
  end

endmodule

// File: tb/tb_iomem_sevenseg.sv
// Self-checking bench for iomem_sevenseg with a short scan period.
// Directed vector tables for the scan plus hand sequences for bus/reset corners.
// Summary line reports check and error counts.
module tb_iomem_sevenseg;

  localparam logic [31:0] A_DATA = 32'h0400_0000;
  localparam logic [31:0] A_CTRL = 32'h0400_0004;
  localparam logic [31:0] A_STAT = 32'h0400_0008;
  localparam logic [31:0] A_RSVD = 32'h0400_000C;

  logic        CLKOUT;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } scan_t;

  scan_t plain_vec[5];
  scan_t dp_vec[4];

  iomem_sevenseg #(.ADDR_HI(8'h04), .TICK_DIV(4)) dut (
    .CLKOUT      (CLKOUT),
    .resetn      (resetn),
    .iomem_valid (valid),
    .iomem_ready (ready),
    .iomem_wstrb (wstrb),
    .iomem_addr  (addr),
    .iomem_wdata (wdata),
    .iomem_rdata (rdata),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  initial CLKOUT = 1'b0;
  always #5 CLKOUT = ~CLKOUT;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_disp(input string nm, input scan_t v);
    chk({nm, "_an"},  {28'h0, an},  {28'h0, v.an});
    chk({nm, "_seg"}, {25'h0, seg}, {25'h0, v.seg});
    chk({nm, "_dp"},  {31'h0, dp},  {31'h0, v.dp});
  endtask

  // One bus transaction; returns on the negedge where ready is seen.
  task automatic bus(input string nm, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
    int n;
    @(negedge CLKOUT);
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    n = 0;
    do begin
      @(negedge CLKOUT);
      n++;
    end while (!ready && n < 8);
    chk({nm, "_latency"}, n, 1);
    r = rdata;
    valid = 1'b0; wstrb = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;

    // digit 0..3 of DATA=1234, then digit 0 again
    plain_vec[0] = '{4'hE, 7'h19, 1'b1};
    plain_vec[1] = '{4'hD, 7'h30, 1'b1};
    plain_vec[2] = '{4'hB, 7'h24, 1'b1};
    plain_vec[3] = '{4'h7, 7'h79, 1'b1};
    plain_vec[4] = '{4'hE, 7'h19, 1'b1};
    // CTRL=0x211: dp on digit 0, digit 1 blanked
    dp_vec[0] = '{4'hE, 7'h19, 1'b0};
    dp_vec[1] = '{4'hF, 7'h30, 1'b1};
    dp_vec[2] = '{4'hB, 7'h24, 1'b1};
    dp_vec[3] = '{4'h7, 7'h79, 1'b1};

    resetn = 1'b0; valid = 1'b0; wstrb = 4'h0; addr = '0; wdata = '0;
    repeat (3) @(negedge CLKOUT);
    chk("rst_ready", {31'h0, ready}, 0);
    chk("rst_rdata", rdata, 0);
    chk_disp("rst", '{4'hF, 7'h7F, 1'b1});
    resetn = 1'b1;

    bus("stat0", A_STAT, 4'h0, 32'h0, r);
    chk("stat0_rdata", r, 0);
    chk("stat0_an", {28'h0, an}, 32'hF);
    bus("data0", A_DATA, 4'h0, 32'h0, r);
    chk("data0_rdata", r, 0);
    bus("ctrl0", A_CTRL, 4'h0, 32'h0, r);
    chk("ctrl0_rdata", r, 0);

    // upper DATA bits are not stored
    bus("wdata", A_DATA, 4'hF, 32'hFFFF_1234, r);
    bus("rdata", A_DATA, 4'h0, 32'h0, r);
    chk("data_rb", r, 32'h0000_1234);

    // enable and follow the scan
    bus("en", A_CTRL, 4'hF, 32'h1, r);
    @(negedge CLKOUT);
    chk_disp("scan0", plain_vec[0]);
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(negedge CLKOUT);
      chk_disp($sformatf("scan%0d", i), plain_vec[i]);
    end
    bus("stat_en", A_STAT, 4'h0, 32'h0, r);
    chk("stat_en_bit", r & 32'h4, 32'h4);

    // disable blanks everything and parks the scan
    bus("dis", A_CTRL, 4'hF, 32'h0, r);
    @(negedge CLKOUT);
    chk_disp("dis", '{4'hF, 7'h7F, 1'b1});
    bus("stat_dis", A_STAT, 4'h0, 32'h0, r);
    chk("stat_dis_rdata", r, 0);

    // re-enable restarts at digit 0; dp and blank in effect
    bus("ctrl211", A_CTRL, 4'hF, 32'h0000_0211, r);
    @(negedge CLKOUT);
    chk_disp("dpscan0", dp_vec[0]);
    for (int i = 1; i < 4; i++) begin
      repeat (4) @(negedge CLKOUT);
      chk_disp($sformatf("dpscan%0d", i), dp_vec[i]);
    end

    // byte-lane write; rdata of the write is the old value
    bus("lane", A_DATA, 4'b0010, 32'h0000_AB00, r);
    chk("lane_prewrite", r, 32'h0000_1234);
    bus("lane_rb", A_DATA, 4'h0, 32'h0, r);
    chk("lane_rdata", r, 32'h0000_AB34);

    // only defined CTRL bits stick
    bus("ctrl_all", A_CTRL, 4'hF, 32'hFFFF_FFFF, r);
    bus("ctrl_all_rb", A_CTRL, 4'h0, 32'h0, r);
    chk("ctrl_all_rdata", r, 32'h0000_0FF1);
    bus("stat_wr", A_STAT, 4'hF, 32'hFFFF_FFFF, r);
    bus("stat_wr_rb", A_STAT, 4'h0, 32'h0, r);
    chk("stat_ro", r & 32'hFFFF_FFFC, 32'h4);

    // reserved offset held valid: ready every second cycle, rdata 0
    bus("pre_rsvd", A_CTRL, 4'h0, 32'h0, r);
    @(negedge CLKOUT);
    valid = 1'b1; addr = A_RSVD; wstrb = 4'hF; wdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLKOUT);
      chk($sformatf("rsvd_ready%0d", k), {31'h0, ready}, k % 2);
      if (ready) chk($sformatf("rsvd_rdata%0d", k), rdata, 0);
    end
    valid = 1'b0; wstrb = 4'h0;
    bus("rsvd_data", A_DATA, 4'h0, 32'h0, r);
    chk("rsvd_data_kept", r, 32'h0000_AB34);
    bus("rsvd_ctrl", A_CTRL, 4'h0, 32'h0, r);
    chk("rsvd_ctrl_kept", r, 32'h0000_0FF1);

    // other address window is never acknowledged
    @(negedge CLKOUT);
    valid = 1'b1; addr = 32'h0500_0000; wstrb = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLKOUT);
      chk($sformatf("miss_ready%0d", k), {31'h0, ready}, 0);
    end
    valid = 1'b0;

    // reset mid-scan and mid-transaction
    bus("en2", A_CTRL, 4'hF, 32'h1, r);
    repeat (3) @(negedge CLKOUT);
    chk("active_an", {31'h0, an == 4'hF}, 0);
    resetn = 1'b0; valid = 1'b1; addr = A_DATA; wstrb = 4'h0;
    @(negedge CLKOUT);
    chk("rst_mid_ready", {31'h0, ready}, 0);
    chk("rst_mid_rdata", rdata, 0);
    chk_disp("rst_mid", '{4'hF, 7'h7F, 1'b1});
    resetn = 1'b1;
    @(negedge CLKOUT);
    chk("rst_served_ready", {31'h0, ready}, 1);
    chk("rst_served_rdata", rdata, 0);
    valid = 1'b0;
    bus("rst_ctrl", A_CTRL, 4'h0, 32'h0, r);
    chk("rst_ctrl_rdata", r, 0);
    chk("rst_an_after", {28'h0, an}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
